bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter that shares the single 16-bit memory/peripheral bus between the CPU (master 0) and a second bus master such as a DMA engine (master 1). It sits between the masters and the address decoder plus slaves, grants ownership per bus cycle (held for the whole `cyc` burst), and routes `ack`/read data back only to the owner. An optional watchdog terminates slave accesses that never acknowledge.

## Interface
- `AW`, default 32: address width.
- `DW`, default 16: data width.
- `TIMEOUT`, default 255: cycles an unacknowledged strobe may stay pending before error (watchdog only).

- `i_clk`  in  1  system clock, all state on rising edge.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_m0_cyc`, `i_m1_cyc`  in  1 each  master bus-cycle request/hold.
- `i_m0_stb`, `i_m1_stb`  in  2 each  byte-lane strobes (`[1]` high byte, `[0]` low byte).
- `i_m0_we`, `i_m1_we`  in  1 each  write enable.
- `i_m0_addr`, `i_m1_addr`  in  AW each  address.
- `i_m0_dat`, `i_m1_dat`  in  DW each  write data.
- `o_m0_dat`, `o_m1_dat`  out  DW each  read data (both driven from `i_dat`).
- `o_m0_ack`, `o_m1_ack`  out  1 each  acknowledge, owner only.
- `o_m0_err`, `o_m1_err`  out  1 each  timeout error pulse, owner only.
- `o_cyc`, `o_stb[1:0]`, `o_we`, `o_addr[AW]`, `o_dat[DW]`  out  shared slave-side bus.
- `i_dat`  in  DW  slave read data, already muxed by the decoder.
- `i_ack`  in  1  slave acknowledge, already muxed by the decoder.
- `o_gnt`  out  2  one-hot current owner (`00` when idle).

## Operation
- States: IDLE, BUS0, BUS1 (2-bit register). Round-robin register `last` (1 bit) = last master granted.
- IDLE: only m0 `cyc` → BUS0; only m1 `cyc` → BUS1; both → the master ≠ `last`; none → stay. On grant, `last` ← granted index.
- BUSx: slave-side outputs combinationally follow master x. Stay while `i_mx_cyc`=1; on `i_mx_cyc`=0 → IDLE.
- IDLE outputs: `o_cyc`, `o_stb`, `o_we`=0, `o_addr`, `o_dat`=0, `o_gnt`=00.
- `o_mx_ack` = `i_ack` & (state==BUSx); the non-owner always sees 0 ack/err. Both `o_mx_dat` = `i_dat`; masters qualify with ack.
- No preemption: a master holding `cyc` keeps the bus indefinitely (watchdog only reports, never revokes).
- Simultaneous owner `cyc` drop and `i_ack`: ack still delivered that cycle; IDLE next.
- Reset (any time, incl. mid-transfer): state=IDLE, `last`=1 (so m0 wins the first contention), watchdog count=0; all outputs 0 immediately.

## Timing
- Grant latency: request sampled in IDLE → slave-side `o_cyc` high the following cycle (1 cycle).
- Release: at least one IDLE cycle with `o_cyc`=0 between owners; back-to-back requests from the other master are granted 2 cycles after the owner drops `cyc`.
- Same master re-requesting immediately after release while the other waits: the other wins (round-robin).
- Ack/data path is combinational; no added latency within an owned cycle.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined: watchdog counter (width $clog2(TIMEOUT+1)) increments each cycle in BUSx with `o_stb`≠0 and `i_ack`=0; clears on `i_ack`, on `o_stb`=0, or in IDLE. When it reaches TIMEOUT, `o_mx_err` pulses 1 cycle for the owner and the counter clears.
- Undefined: no counter; `o_m0_err`, `o_m1_err` tied 0; `TIMEOUT` unused.

## Structure
- Shared package `dcpu_bus_pkg`: state encoding (IDLE=0, BUS0=1, BUS1=2), master index constants, strobe width constant (2).
- One sub-module `bus_watchdog` (counter + compare, err pulse out), instantiated only under `BUS_ARB_TIMEOUT_EN`.

## Test plan
- Reset: hold `i_reset_n`=0 with both `cyc`=1 → all outputs 0, `o_gnt`=00; release → BUS0 next cycle, `o_gnt`=01.
- Single master: m1 write addr 0x0010, dat 0xBEEF, stb 11; slave acks → `o_addr`=0x0010, `o_dat`=0xBEEF, `o_m1_ack`=1, `o_m0_ack`=0.
- Contention: both `cyc` high continuously, each dropping after one ack → grants alternate 01,00,10,00,01.
- Hold: m0 holds `cyc` for 3 acked reads while m1 requests → `o_gnt` stays 01 until m0 drops, m1 granted 2 cycles later.
- Mid-transfer reset: assert `i_reset_n`=0 during BUS1 strobe → `o_cyc`=0 same cycle; after release with only m1 requesting, BUS1 regained after 1 cycle.
- Watchdog (macro on, TIMEOUT=4): m0 strobes, `i_ack` never → `o_m0_err` single-cycle pulse 4 cycles after strobe; macro off → never asserted.

Source files
------------

// File: rtl/dcpu_bus_pkg.sv
// Shared bus definitions for the dcpu master/slave fabric.
// State encoding, master indices and strobe width.
package dcpu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS0 = 2'd1,
      ST_BUS1 = 2'd2
   } state_t;

   localparam int M0    = 0;
   localparam int M1    = 1;
   localparam int STB_W = 2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Two-master bus bundle between masters, arbiter and slave decoder.
// slave: arbiter view; master: environment view.
interface bus_arbiter_if
   import dcpu_bus_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 16
) ();

   logic             i_m0_cyc;
   logic             i_m1_cyc;
   logic [STB_W-1:0] i_m0_stb;
   logic [STB_W-1:0] i_m1_stb;
   logic             i_m0_we;
   logic             i_m1_we;
   logic [AW-1:0]    i_m0_addr;
   logic [AW-1:0]    i_m1_addr;
   logic [DW-1:0]    i_m0_dat;
   logic [DW-1:0]    i_m1_dat;
   logic [DW-1:0]    o_m0_dat;
   logic [DW-1:0]    o_m1_dat;
   logic             o_m0_ack;
   logic             o_m1_ack;
   logic             o_m0_err;
   logic             o_m1_err;
   logic             o_cyc;
   logic [STB_W-1:0] o_stb;
   logic             o_we;
   logic [AW-1:0]    o_addr;
   logic [DW-1:0]    o_dat;
   logic [DW-1:0]    i_dat;
   logic             i_ack;
   logic [1:0]       o_gnt;

   modport slave (
      input  i_m0_cyc, i_m1_cyc,
      input  i_m0_stb, i_m1_stb,
      input  i_m0_we, i_m1_we,
      input  i_m0_addr, i_m1_addr,
      input  i_m0_dat, i_m1_dat,
      input  i_dat, i_ack,
      output o_m0_dat, o_m1_dat,
      output o_m0_ack, o_m1_ack,
      output o_m0_err, o_m1_err,
      output o_cyc, o_stb, o_we,
      output o_addr, o_dat, o_gnt
   );

   modport master (
      output i_m0_cyc, i_m1_cyc,
      output i_m0_stb, i_m1_stb,
      output i_m0_we, i_m1_we,
      output i_m0_addr, i_m1_addr,
      output i_m0_dat, i_m1_dat,
      output i_dat, i_ack,
      input  o_m0_dat, o_m1_dat,
      input  o_m0_ack, o_m1_ack,
      input  o_m0_err, o_m1_err,
      input  o_cyc, o_stb, o_we,
      input  o_addr, o_dat, o_gnt
   );

endinterface

// File: rtl/bus_watchdog.sv
// Strobe watchdog: one-cycle err pulse after TIMEOUT unacked cycles.
// Used by bus_arbiter only when BUS_ARB_TIMEOUT_EN is defined.
module bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_active,
   input  logic i_ack,
   output logic o_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // Count pending strobe cycles; wrap to zero and flag on expiry
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt   <= '0;
         o_err <= 1'b0;
      end else begin
         o_err <= 1'b0;
         if (i_active && !i_ack) begin
            if (cnt == CW'(TIMEOUT - 1)) begin
               cnt   <= '0;
               o_err <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter, ownership held for a cyc burst.
// Optional strobe watchdog enabled by `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
   import dcpu_bus_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   bus_arbiter_if.slave  bus
);

   state_t state;
   logic   last;
   logic   own0;
   logic   own1;

   assign own0 = (state == ST_BUS0);
   assign own1 = (state == ST_BUS1);

   // Grant FSM: round-robin on contention, release only on cyc drop
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_IDLE;
         last  <= 1'(M1);
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.i_m0_cyc && (!bus.i_m1_cyc || last)) begin
                  state <= ST_BUS0;
                  last  <= 1'(M0);
               end else if (bus.i_m1_cyc) begin
                  state <= ST_BUS1;
                  last  <= 1'(M1);
               end
            end
            ST_BUS0: if (!bus.i_m0_cyc) state <= ST_IDLE;
            ST_BUS1: if (!bus.i_m1_cyc) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Slave-side bus follows the owner; all zero while idle
   always_comb begin
      bus.o_cyc  = 1'b0;
      bus.o_stb  = '0;
      bus.o_we   = 1'b0;
      bus.o_addr = '0;
      bus.o_dat  = '0;
      unique case (1'b1)
         own0: begin
            bus.o_cyc  = bus.i_m0_cyc;
            bus.o_stb  = bus.i_m0_stb;
            bus.o_we   = bus.i_m0_we;
            bus.o_addr = bus.i_m0_addr;
            bus.o_dat  = bus.i_m0_dat;
         end
         own1: begin
            bus.o_cyc  = bus.i_m1_cyc;
            bus.o_stb  = bus.i_m1_stb;
            bus.o_we   = bus.i_m1_we;
            bus.o_addr = bus.i_m1_addr;
            bus.o_dat  = bus.i_m1_dat;
         end
         default: ;
      endcase
   end

   assign bus.o_gnt    = {own1, own0};
   assign bus.o_m0_ack = bus.i_ack & own0;
   assign bus.o_m1_ack = bus.i_ack & own1;
   assign bus.o_m0_dat = bus.i_dat;
   assign bus.o_m1_dat = bus.i_dat;

`ifdef BUS_ARB_TIMEOUT_EN
   logic wd_err;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_active  ((own0 | own1) & (|bus.o_stb)),
      .i_ack     (bus.i_ack),
      .o_err     (wd_err)
   );

   assign bus.o_m0_err = wd_err & own0;
   assign bus.o_m1_err = wd_err & own1;
`else
   logic unused_tmo;

   assign unused_tmo   = ^TIMEOUT;
   assign bus.o_m0_err = 1'b0;
   assign bus.o_m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic.
// Watchdog expectations follow BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter;
   import dcpu_bus_pkg::*;

   localparam int AW  = 32;
   localparam int DW  = 16;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic          mcyc  [2];
   logic [1:0]    mstb  [2];
   logic          mwe   [2];
   logic [AW-1:0] maddr [2];
   logic [DW-1:0] mdat  [2];
   logic          sack;
   logic [DW-1:0] sdat;

   bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   assign bus.i_m0_cyc  = mcyc[0];
   assign bus.i_m1_cyc  = mcyc[1];
   assign bus.i_m0_stb  = mstb[0];
   assign bus.i_m1_stb  = mstb[1];
   assign bus.i_m0_we   = mwe[0];
   assign bus.i_m1_we   = mwe[1];
   assign bus.i_m0_addr = maddr[0];
   assign bus.i_m1_addr = maddr[1];
   assign bus.i_m0_dat  = mdat[0];
   assign bus.i_m1_dat  = mdat[1];
   assign bus.i_ack     = sack;
   assign bus.i_dat     = sdat;

   bus_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TMO)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   // reference model: owner (-1 idle), last winner, pending strobe age
   int owner = -1;
   int lastw = 1;
   int wcnt = 0;
   bit errq = 1'b0;

   logic [1:0]    seen_gnt;
   logic          seen_cyc;
   logic          seen_ack0;
   logic          seen_ack1;
   logic          seen_err0;
   logic [AW-1:0] seen_addr;
   logic [DW-1:0] seen_dat;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // one clock: check outputs mid-cycle, then advance the model
   task automatic tick();
      logic          e_cyc;
      logic [1:0]    e_stb;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_dat;
      logic [1:0]    e_gnt;
      bit            e_err;
      #1;
      if (!rst_n) begin
         owner = -1;
         lastw = 1;
         wcnt  = 0;
         errq  = 1'b0;
      end
      e_cyc = 1'b0; e_stb = '0; e_we = 1'b0;
      e_addr = '0; e_dat = '0; e_gnt = 2'b00;
      if (owner >= 0) begin
         e_cyc  = mcyc[owner];
         e_stb  = mstb[owner];
         e_we   = mwe[owner];
         e_addr = maddr[owner];
         e_dat  = mdat[owner];
         e_gnt  = (owner == 0) ? 2'b01 : 2'b10;
      end
`ifdef BUS_ARB_TIMEOUT_EN
      e_err = errq;
`else
      e_err = 1'b0;
`endif
      chk("gnt",  64'(bus.o_gnt),  64'(e_gnt));
      chk("cyc",  64'(bus.o_cyc),  64'(e_cyc));
      chk("stb",  64'(bus.o_stb),  64'(e_stb));
      chk("we",   64'(bus.o_we),   64'(e_we));
      chk("addr", 64'(bus.o_addr), 64'(e_addr));
      chk("wdat", 64'(bus.o_dat),  64'(e_dat));
      chk("ack0", 64'(bus.o_m0_ack), 64'(sack && owner == 0));
      chk("ack1", 64'(bus.o_m1_ack), 64'(sack && owner == 1));
      chk("err0", 64'(bus.o_m0_err), 64'(e_err && owner == 0));
      chk("err1", 64'(bus.o_m1_err), 64'(e_err && owner == 1));
      chk("rd0",  64'(bus.o_m0_dat), 64'(sdat));
      chk("rd1",  64'(bus.o_m1_dat), 64'(sdat));
      seen_gnt  = bus.o_gnt;
      seen_cyc  = bus.o_cyc;
      seen_ack0 = bus.o_m0_ack;
      seen_ack1 = bus.o_m1_ack;
      seen_err0 = bus.o_m0_err;
      seen_addr = bus.o_addr;
      seen_dat  = bus.o_dat;
      @(posedge clk);
      if (rst_n) begin
         if (owner >= 0 && mstb[owner] != 2'b00 && !sack) begin
            wcnt++;
            errq = (wcnt == TMO);
            if (errq) wcnt = 0;
         end else begin
            wcnt = 0;
            errq = 1'b0;
         end
         if (owner < 0) begin
            if (mcyc[0] && mcyc[1]) owner = 1 - lastw;
            else if (mcyc[0]) owner = 0;
            else if (mcyc[1]) owner = 1;
            if (owner >= 0) lastw = owner;
         end else if (!mcyc[owner]) begin
            owner = -1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         mcyc[i] = 1'b0; mstb[i] = 2'b00; mwe[i] = 1'b0;
         maddr[i] = '0; mdat[i] = '0;
      end
      sack = 1'b0;
      sdat = 16'h1234;
      @(negedge clk);

      // reset held with both requesting
      mcyc[0] = 1'b1; mcyc[1] = 1'b1;
      mstb[0] = 2'b11; mstb[1] = 2'b11;
      tick();
      chk("rst_gnt", 64'(seen_gnt), 64'(2'b00));
      chk("rst_cyc", 64'(seen_cyc), 64'(1'b0));
      rst_n = 1'b1;
      tick();
      tick();
      chk("rst_rel", 64'(seen_gnt), 64'(2'b01));
      mcyc[0] = 1'b0; mcyc[1] = 1'b0;
      tick();
      tick();

      // single master write from m1
      mcyc[1] = 1'b1; mwe[1] = 1'b1; mstb[1] = 2'b11;
      maddr[1] = 32'h0000_0010; mdat[1] = 16'hBEEF;
      tick();
      sack = 1'b1;
      tick();
      chk("s_addr", 64'(seen_addr), 64'h10);
      chk("s_dat",  64'(seen_dat),  64'hBEEF);
      chk("s_ack1", 64'(seen_ack1), 64'(1'b1));
      chk("s_ack0", 64'(seen_ack0), 64'(1'b0));
      sack = 1'b0; mcyc[1] = 1'b0;
      tick();

      // contention: owner drops cyc on its ack, then re-requests
      mcyc[0] = 1'b1; mcyc[1] = 1'b1;
      tick();
      mcyc[0] = 1'b0; sack = 1'b1;
      tick();
      chk("ct_g0", 64'(seen_gnt), 64'(2'b01));
      chk("ct_a0", 64'(seen_ack0), 64'(1'b1));
      mcyc[0] = 1'b1; sack = 1'b0;
      tick();
      chk("ct_g1", 64'(seen_gnt), 64'(2'b00));
      mcyc[1] = 1'b0; sack = 1'b1;
      tick();
      chk("ct_g2", 64'(seen_gnt), 64'(2'b10));
      mcyc[1] = 1'b1; sack = 1'b0;
      tick();
      chk("ct_g3", 64'(seen_gnt), 64'(2'b00));
      mcyc[0] = 1'b0; sack = 1'b1;
      tick();
      chk("ct_g4", 64'(seen_gnt), 64'(2'b01));
      mcyc[1] = 1'b0; sack = 1'b0;
      tick();

      // hold: m0 keeps the bus over three acked reads
      mcyc[0] = 1'b1; mwe[0] = 1'b0; mstb[0] = 2'b01;
      tick();
      mcyc[1] = 1'b1;
      for (int j = 0; j < 6; j++) begin
         sack = j[0];
         sdat = 16'(j * 16'h1111);
         tick();
         chk("hold", 64'(seen_gnt), 64'(2'b01));
      end
      sack = 1'b0; mcyc[0] = 1'b0;
      tick();
      tick();
      chk("hold_gap", 64'(seen_gnt), 64'(2'b00));
      tick();
      chk("hold_m1", 64'(seen_gnt), 64'(2'b10));

      // asynchronous reset in the middle of a BUS1 strobe
      rst_n = 1'b0;
      tick();
      chk("mr_cyc", 64'(seen_cyc), 64'(1'b0));
      chk("mr_gnt", 64'(seen_gnt), 64'(2'b00));
      rst_n = 1'b1;
      tick();
      tick();
      chk("mr_regain", 64'(seen_gnt), 64'(2'b10));
      mcyc[1] = 1'b0;
      tick();
      tick();

      // watchdog: m0 strobes and the slave never answers
      mcyc[0] = 1'b1; mstb[0] = 2'b11; sack = 1'b0;
      tick();
      for (int k = 0; k < 7; k++) begin
         tick();
`ifdef BUS_ARB_TIMEOUT_EN
         chk("wd_err", 64'(seen_err0), 64'(k == TMO));
`else
         chk("wd_off", 64'(seen_err0), 64'(1'b0));
`endif
      end
      mcyc[0] = 1'b0;
      tick();

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(3) == 0) mcyc[i] = ~mcyc[i];
            mstb[i]  = 2'($urandom_range(3));
            mwe[i]   = 1'($urandom_range(1));
            maddr[i] = $urandom;
            mdat[i]  = 16'($urandom);
         end
         sack  = ($urandom_range(2) == 0);
         sdat  = 16'($urandom);
         rst_n = ($urandom_range(199) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
